// File: rtl/fifo_join_pair.sv
// Paired TX/RX FIFO for one PIO state machine. TX carries data from the core
// to the state machine. RX carries data from the state machine to the core.
// The two DEPTH-entry banks live in one array: TX owns [0, DEPTH) and RX owns
// [DEPTH, 2*DEPTH). A joined side uses the whole array as one circular buffer.
// Storage is never reset. Only the pointers, counts, read data and flags are.
module fifo_join_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        join_mode,
  input  logic                              tx_push_en,
  input  logic [WIDTH-1:0]                  tx_data_in,
  input  logic                              tx_pop_en,
  output logic [WIDTH-1:0]                  tx_data_out,
  output logic                              tx_empty,
  output logic                              tx_full,
  output logic [$clog2(2*DEPTH):0]          tx_count,
  input  logic                              rx_push_en,
  input  logic [WIDTH-1:0]                  rx_data_in,
  input  logic                              rx_pop_en,
  output logic [WIDTH-1:0]                  rx_data_out,
  output logic                              rx_empty,
  output logic                              rx_full,
  output logic [$clog2(2*DEPTH):0]          rx_count,
  input  logic [3:0]                        flag_clr,
  output logic [3:0]                        flags
);

  localparam int CW = $clog2(2*DEPTH) + 1;
  localparam int PW = $clog2(2*DEPTH);

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_JTX  = 2'b01,
    MODE_JRX  = 2'b10
  } mode_e;

  logic [WIDTH-1:0] mem [2*DEPTH];

  mode_e            mode_q, mode_s;
  logic [PW-1:0]    tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0]    tx_cnt_q, rx_cnt_q;
  logic [WIDTH-1:0] tx_dout_q, rx_dout_q;
  logic [3:0]       flags_q, flags_d;

  logic             join_chg_s, tx_act_s, rx_act_s;
  logic [CW-1:0]    tx_cap_s, rx_cap_s;
  logic [PW-1:0]    tx_mask_s, rx_mask_s;
  logic [PW-1:0]    rx_wr_addr_s, rx_rd_addr_s;
  logic             tx_pop_ok_s, tx_push_ok_s, rx_pop_ok_s, rx_push_ok_s;
  logic             tx_over_s, tx_under_s, rx_over_s, rx_under_s;

  // Decode the requested mode (11 is treated as no join) and the per-side capacity.
  always_comb begin
    case (join_mode)
      2'b01:   mode_s = MODE_JTX;
      2'b10:   mode_s = MODE_JRX;
      default: mode_s = MODE_NONE;
    endcase
    case (mode_q)
      MODE_JTX: begin
        tx_cap_s  = CW'(2*DEPTH);
        rx_cap_s  = {CW{1'b0}};
        tx_mask_s = PW'(2*DEPTH-1);
        rx_mask_s = PW'(DEPTH-1);
      end
      MODE_JRX: begin
        tx_cap_s  = {CW{1'b0}};
        rx_cap_s  = CW'(2*DEPTH);
        tx_mask_s = PW'(DEPTH-1);
        rx_mask_s = PW'(2*DEPTH-1);
      end
      default: begin
        tx_cap_s  = CW'(DEPTH);
        rx_cap_s  = CW'(DEPTH);
        tx_mask_s = PW'(DEPTH-1);
        rx_mask_s = PW'(DEPTH-1);
      end
    endcase
  end

  // Accept or reject push/pop on each side and raise the sticky error flags.
  // A disabled side and a join-change cycle both ignore every request.
  always_comb begin
    join_chg_s   = (mode_s != mode_q);
    tx_act_s     = rst && !join_chg_s && (mode_q != MODE_JRX);
    rx_act_s     = rst && !join_chg_s && (mode_q != MODE_JTX);
    tx_pop_ok_s  = tx_act_s && tx_pop_en && !tx_empty;
    tx_push_ok_s = tx_act_s && tx_push_en && (!tx_full || tx_pop_ok_s);
    tx_over_s    = tx_act_s && tx_push_en && tx_full && !tx_pop_ok_s;
    tx_under_s   = tx_act_s && tx_pop_en && tx_empty;
    rx_pop_ok_s  = rx_act_s && rx_pop_en && !rx_empty;
    rx_push_ok_s = rx_act_s && rx_push_en && (!rx_full || rx_pop_ok_s);
    rx_over_s    = rx_act_s && rx_push_en && rx_full && !rx_pop_ok_s;
    rx_under_s   = rx_act_s && rx_pop_en && rx_empty;
    // RX addresses start at the second bank, so the joined RX buffer wraps through bank 0.
    rx_wr_addr_s = rx_wr_q + PW'(DEPTH);
    rx_rd_addr_s = rx_rd_q + PW'(DEPTH);
    // A new error event takes priority over a clear of the same bit.
    flags_d      = (flags_q & ~flag_clr) | {rx_under_s, rx_over_s, tx_under_s, tx_over_s};
  end

  // Status outputs: a disabled side reads as both empty and full.
  always_comb begin
    tx_empty    = (tx_cnt_q == {CW{1'b0}});
    rx_empty    = (rx_cnt_q == {CW{1'b0}});
    tx_full     = (mode_q == MODE_JRX) || (tx_cnt_q == tx_cap_s);
    rx_full     = (mode_q == MODE_JTX) || (rx_cnt_q == rx_cap_s);
    tx_count    = tx_cnt_q;
    rx_count    = rx_cnt_q;
    tx_data_out = tx_dout_q;
    rx_data_out = rx_dout_q;
    flags       = flags_q;
  end

  // Word storage. It has no reset, and a write is only ever made into a free slot.
  always_ff @(posedge clk) begin
    if (tx_push_ok_s) mem[tx_wr_q] <= tx_data_in;
    if (rx_push_ok_s) mem[rx_wr_addr_s] <= rx_data_in;
  end

  // Pointers, counts, registered read data, mode and flags.
  always_ff @(posedge clk) begin
    mode_q <= mode_s;
    if (!rst) begin
      tx_wr_q   <= {PW{1'b0}};
      tx_rd_q   <= {PW{1'b0}};
      rx_wr_q   <= {PW{1'b0}};
      rx_rd_q   <= {PW{1'b0}};
      tx_cnt_q  <= {CW{1'b0}};
      rx_cnt_q  <= {CW{1'b0}};
      tx_dout_q <= {WIDTH{1'b0}};
      rx_dout_q <= {WIDTH{1'b0}};
      flags_q   <= 4'b0000;
    end else begin
      flags_q <= flags_d;
      if (join_chg_s) begin
        tx_wr_q  <= {PW{1'b0}};
        tx_rd_q  <= {PW{1'b0}};
        rx_wr_q  <= {PW{1'b0}};
        rx_rd_q  <= {PW{1'b0}};
        tx_cnt_q <= {CW{1'b0}};
        rx_cnt_q <= {CW{1'b0}};
      end else begin
        if (tx_push_ok_s) tx_wr_q <= (tx_wr_q + PW'(1)) & tx_mask_s;
        if (rx_push_ok_s) rx_wr_q <= (rx_wr_q + PW'(1)) & rx_mask_s;
        if (tx_pop_ok_s) begin
          tx_dout_q <= mem[tx_rd_q];
          tx_rd_q   <= (tx_rd_q + PW'(1)) & tx_mask_s;
        end
        if (rx_pop_ok_s) begin
          rx_dout_q <= mem[rx_rd_addr_s];
          rx_rd_q   <= (rx_rd_q + PW'(1)) & rx_mask_s;
        end
        tx_cnt_q <= tx_cnt_q + CW'(tx_push_ok_s) - CW'(tx_pop_ok_s);
        rx_cnt_q <= rx_cnt_q + CW'(rx_push_ok_s) - CW'(rx_pop_ok_s);
      end
    end
  end

endmodule

// File: tb/tb_fifo_join_pair.sv
// Directed testbench for fifo_join_pair with WIDTH=32 and DEPTH=4.
module tb_fifo_join_pair;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  join_mode;
  logic        tx_push_en, tx_pop_en, rx_push_en, rx_pop_en;
  logic [31:0] tx_data_in, rx_data_in;
  logic [31:0] tx_data_out, rx_data_out;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic [3:0]  tx_count, rx_count;
  logic [3:0]  flag_clr, flags;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_join_pair #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .join_mode(join_mode),
    .tx_push_en(tx_push_en), .tx_data_in(tx_data_in), .tx_pop_en(tx_pop_en),
    .tx_data_out(tx_data_out), .tx_empty(tx_empty), .tx_full(tx_full), .tx_count(tx_count),
    .rx_push_en(rx_push_en), .rx_data_in(rx_data_in), .rx_pop_en(rx_pop_en),
    .rx_data_out(rx_data_out), .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
    .flag_clr(flag_clr), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock edge. Outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_push_en = 1'b0; tx_pop_en = 1'b0;
    rx_push_en = 1'b0; rx_pop_en = 1'b0;
    flag_clr   = 4'b0000;
  endtask

  task automatic tx_push(input logic [31:0] d);
    tx_push_en = 1'b1; tx_data_in = d; tick(); tx_push_en = 1'b0;
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_push_en = 1'b1; rx_data_in = d; tick(); rx_push_en = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_q [$];
    rst = 1'b0; join_mode = 2'b00; tx_data_in = 32'h0; rx_data_in = 32'h0;
    idle();
    tick(); tick();
    rst = 1'b1;
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_tx_empty", 32'(tx_empty), 32'd1);
    chk("rst_tx_full",  32'(tx_full),  32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_flags",    32'(flags),    32'd0);
    chk("rst_tx_dout",  tx_data_out,   32'd0);

    // Fill TX in no-join mode, overflow it once, then drain it.
    tx_push(32'hA); tx_push(32'hB); tx_push(32'hC); tx_push(32'hD);
    chk("tx_full4",  32'(tx_full),  32'd1);
    chk("tx_count4", 32'(tx_count), 32'd4);
    tx_push(32'hE);
    chk("tx_over_flag", 32'(flags), 32'h1);
    chk("tx_over_cnt",  32'(tx_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      tx_pop_en = 1'b1; tick();
      chk("tx_pop_data", tx_data_out, 32'hA + 32'(i));
    end
    tx_pop_en = 1'b0;
    chk("tx_empty_after", 32'(tx_empty), 32'd1);
    flag_clr = 4'b1111; tick(); flag_clr = 4'b0000;
    chk("flags_cleared", 32'(flags), 32'd0);

    // Join TX. Offset the pointers by 3 so that 8 words wrap across both banks.
    join_mode = 2'b01; tick();
    chk("jtx_rx_full",  32'(rx_full),  32'd1);
    chk("jtx_rx_empty", 32'(rx_empty), 32'd1);
    for (int i = 0; i < 3; i++) tx_push(32'h90 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      tx_pop_en = 1'b1; tick();
      chk("jtx_pre_pop", tx_data_out, 32'h90 + 32'(i));
    end
    tx_pop_en = 1'b0;
    for (int i = 1; i <= 8; i++) tx_push(32'(i));
    chk("jtx_count8", 32'(tx_count), 32'd8);
    chk("jtx_full",   32'(tx_full),  32'd1);
    rx_push(32'hDEAD);
    chk("jtx_rx_ignored_cnt", 32'(rx_count), 32'd0);
    chk("jtx_rx_ignored_flg", 32'(flags),    32'd0);
    for (int i = 1; i <= 8; i++) begin
      tx_pop_en = 1'b1; tick();
      chk("jtx_pop_data", tx_data_out, 32'(i));
    end
    tx_pop_en = 1'b0;
    chk("jtx_empty", 32'(tx_empty), 32'd1);

    // Back to no join: TX full with a simultaneous push and pop.
    join_mode = 2'b00; tick();
    chk("njoin_tx_cnt0",   32'(tx_count), 32'd0);
    chk("njoin_dout_kept", tx_data_out,   32'd8);
    for (int i = 0; i < 4; i++) tx_push(32'h11 + 32'(i));
    tx_push_en = 1'b1; tx_data_in = 32'h55; tx_pop_en = 1'b1; tick(); idle();
    chk("fullpp_count", 32'(tx_count), 32'd4);
    chk("fullpp_data",  tx_data_out,   32'h11);
    chk("fullpp_flags", 32'(flags),    32'd0);
    exp_q = '{32'h12, 32'h13, 32'h14, 32'h55};
    foreach (exp_q[i]) begin
      tx_pop_en = 1'b1; tick();
      chk("fullpp_drain", tx_data_out, exp_q[i]);
    end
    tx_pop_en = 1'b0;

    // RX empty with a simultaneous push and pop: the push lands and the pop underflows.
    rx_push_en = 1'b1; rx_data_in = 32'h77; rx_pop_en = 1'b1; tick(); idle();
    chk("emptypp_count", 32'(rx_count), 32'd1);
    chk("emptypp_dout",  rx_data_out,   32'd0);
    chk("emptypp_flags", 32'(flags),    32'b1000);
    rx_pop_en = 1'b1; tick(); rx_pop_en = 1'b0;
    chk("emptypp_next", rx_data_out, 32'h77);
    flag_clr = 4'b1000; tick(); flag_clr = 4'b0000;
    chk("rx_under_clr", 32'(flags), 32'd0);

    // Three words in TX, then switch to join-RX with a push in the same cycle.
    tx_push(32'h21); tx_push(32'h22); tx_push(32'h23);
    join_mode = 2'b10; tx_push_en = 1'b1; tx_data_in = 32'h99; tick(); idle();
    chk("jrx_tx_cnt",   32'(tx_count), 32'd0);
    chk("jrx_rx_cnt",   32'(rx_count), 32'd0);
    chk("jrx_tx_dout",  tx_data_out,   32'h55);
    chk("jrx_tx_full",  32'(tx_full),  32'd1);
    chk("jrx_tx_empty", 32'(tx_empty), 32'd1);
    for (int i = 0; i < 8; i++) rx_push(32'h31 + 32'(i));
    chk("jrx_rx_cnt8", 32'(rx_count), 32'd8);
    chk("jrx_rx_full", 32'(rx_full),  32'd1);

    // Sticky flag: a clear alone wins, but a new overflow beats a clear.
    rx_push(32'h3F);
    chk("rx_over_set", 32'(flags), 32'b0100);
    flag_clr = 4'b0100; tick(); flag_clr = 4'b0000;
    chk("rx_over_clr", 32'(flags), 32'd0);
    flag_clr = 4'b0100; rx_push_en = 1'b1; rx_data_in = 32'h40; tick(); idle();
    chk("rx_set_wins", 32'(flags), 32'b0100);
    rx_pop_en = 1'b1; tick(); rx_pop_en = 1'b0;
    chk("jrx_pop_first", rx_data_out, 32'h31);
    chk("jrx_pop_cnt",   32'(rx_count), 32'd7);

    // Reset in mid-stream while pushes are pending.
    rst = 1'b0; rx_push_en = 1'b1; tx_push_en = 1'b1; tick(); idle(); rst = 1'b1;
    chk("mrst_rx_cnt",  32'(rx_count), 32'd0);
    chk("mrst_rx_dout", rx_data_out,   32'd0);
    chk("mrst_tx_dout", tx_data_out,   32'd0);
    chk("mrst_flags",   32'(flags),    32'd0);
    chk("mrst_rx_empty", 32'(rx_empty), 32'd1);
    chk("mrst_rx_full",  32'(rx_full),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
